// File: rtl/ram_tdp_arbiter.sv
// ram_tdp_arbiter
//   Shares one true dual-port, write-first block RAM among three requesters
//   and provides a run-time engine that zeroes the whole array.
//
//   Port A belongs to requester 0 (CPU data side) at fixed priority.
//   Port B is shared round-robin between requester 1 (DMA) and requester 2
//   (debug). While a clear runs, both RAM ports are taken over and each cycle
//   zeroes one even/odd address pair. The RAM has one clock of read latency.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   clear_start          request a full-array clear (ignored while clearing)
//   clear_busy           clear in progress
//   clear_done           one-cycle pulse in the first idle cycle after a clear
//   mN_req/we/addr/din   requester N command, held until mN_ack (N = 0,1,2)
//   mN_ack               command accepted this cycle (combinational)
//   mN_rvalid/rdata      read response, one cycle after a read ack
//   ram_*a / ram_*b      RAM port A / port B controls and read data
module ram_tdp_arbiter #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_ack,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_ack,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  input  logic                  m2_req,
  input  logic                  m2_we,
  input  logic [ADDR_WIDTH-1:0] m2_addr,
  input  logic [DATA_WIDTH-1:0] m2_din,
  output logic                  m2_ack,
  output logic                  m2_rvalid,
  output logic [DATA_WIDTH-1:0] m2_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic                  ram_wea,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,

  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_web,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  // Clear counter indexes address pairs; with a single-bit address there is
  // only one pair, so a 1-bit counter that never advances is kept.
  localparam int unsigned CW = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rr_q, rr_d;       // 0: m1 favoured, 1: m2 favoured
  logic                  done_q, done_d;
  logic                  m0_rvalid_q, m1_rvalid_q, m2_rvalid_q;

  logic                  busy;
  logic                  win;
  logic                  clr_last;
  logic                  gnt1, gnt2;
  logic [ADDR_WIDTH-1:0] clr_addr_a, clr_addr_b;

  assign busy = (state_q == ST_CLEAR);

  // clear_start takes precedence over any request issued in the same cycle.
  assign win = (state_q == ST_IDLE) & ~clear_start;

  generate
    if (ADDR_WIDTH > 1) begin : g_clr_wide
      assign clr_addr_a = {cnt_q, 1'b0};
      assign clr_addr_b = {cnt_q, 1'b1};
      assign clr_last   = (cnt_q == '1);
    end else begin : g_clr_narrow
      assign clr_addr_a = '0;
      assign clr_addr_b = '1;
      assign clr_last   = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign m0_ack = win & m0_req;

  // A lone requester always wins; on contention the pointer decides.
  assign gnt1 = win & m1_req & (~m2_req | ~rr_q);
  assign gnt2 = win & m2_req & (~m1_req |  rr_q);

  assign m1_ack = gnt1;
  assign m2_ack = gnt2;

  always_comb begin
    rr_d = rr_q;
    if (gnt1) begin
      rr_d = 1'b1;
    end else if (gnt2) begin
      rr_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    if (busy) begin
      ram_addra = clr_addr_a;
      ram_dina  = '0;
      ram_wea   = 1'b1;
    end else begin
      ram_addra = m0_addr;
      ram_dina  = m0_din;
      ram_wea   = m0_ack & m0_we;
    end
  end

  always_comb begin
    if (busy) begin
      ram_addrb = clr_addr_b;
      ram_dinb  = '0;
      ram_web   = 1'b1;
    end else begin
      ram_addrb = gnt2 ? m2_addr : m1_addr;
      ram_dinb  = gnt2 ? m2_din  : m1_din;
      ram_web   = (gnt1 & m1_we) | (gnt2 & m2_we);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      done_q      <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m2_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      done_q      <= done_d;
      m0_rvalid_q <= m0_ack & ~m0_we;
      m1_rvalid_q <= gnt1 & ~m1_we;
      m2_rvalid_q <= gnt2 & ~m2_we;
    end
  end

  assign clear_busy = busy;
  assign clear_done = done_q;

  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m2_rvalid  = m2_rvalid_q;

  assign m0_rdata   = ram_douta;
  assign m1_rdata   = ram_doutb;
  assign m2_rdata   = ram_doutb;

endmodule

// File: tb/tb_ram_tdp_arbiter.sv
// Bench for ram_tdp_arbiter: drives directed and random traffic, models the
// RAM behind the controller, and checks every cycle against a reference
// model of the memory contents, grant rules and clear sequence.
module tb_ram_tdp_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_start, clear_busy, clear_done;
  logic          m0_req, m0_we, m0_ack, m0_rvalid;
  logic          m1_req, m1_we, m1_ack, m1_rvalid;
  logic          m2_req, m2_we, m2_ack, m2_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, m2_addr;
  logic [DW-1:0] m0_din, m1_din, m2_din;
  logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic          ram_wea, ram_web;
  logic [DW-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;

  always #5 clk = ~clk;

  ram_tdp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr), .m2_din(m2_din),
    .m2_ack(m2_ack), .m2_rvalid(m2_rvalid), .m2_rdata(m2_rdata),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .ram_addrb(ram_addrb), .ram_web(ram_web), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
  );

  // Write-first true dual-port RAM, zero-initialised, one-cycle read latency.
  logic [DW-1:0] ram [DEPTH] = '{default: '0};

  always @(posedge clk) begin
    if (ram_wea) begin
      ram[ram_addra] <= ram_dina;
      ram_douta      <= ram_dina;
    end else begin
      ram_douta      <= ram[ram_addra];
    end
    if (ram_web) begin
      ram[ram_addrb] <= ram_dinb;
      ram_doutb      <= ram_dinb;
    end else begin
      ram_doutb      <= ram[ram_addrb];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
  bit            clr_on;
  int            clr_k;
  bit            done_flag;
  int            fav;            // requester favoured on port-B contention
  bit            pend_rv  [3];
  logic [DW-1:0] pend_dat [3];

  int n_total = 0;
  int n_bad   = 0;
  int busy_seen, done_seen;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    clr_on    = 1'b0;
    clr_k     = 0;
    done_flag = 1'b0;
    fav       = 1;
    for (int i = 0; i < 3; i++) pend_rv[i] = 1'b0;
  endtask

  task automatic set_idle();
    clear_start = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_din = '0;
    m2_req = 1'b0; m2_we = 1'b0; m2_addr = '0; m2_din = '0;
  endtask

  // Called just after a falling edge with inputs already driven; checks this
  // cycle against the model, advances the model, returns at the next falling edge.
  task automatic step();
    bit            win, a0, a1, a2, ewa, ewb, ndone;
    bit            nrv  [3];
    logic [DW-1:0] ndat [3];
    #1;
    if (clear_busy) busy_seen++;
    if (clear_done) done_seen++;
    check_eq("busy", DW'(clear_busy), DW'(clr_on));
    check_eq("done", DW'(clear_done), DW'(done_flag));

    win = !clr_on && !clear_start;
    a0  = win && m0_req;
    if (win && m1_req && m2_req) begin
      a1 = (fav == 1);
      a2 = (fav == 2);
    end else begin
      a1 = win && m1_req;
      a2 = win && m2_req;
    end
    check_eq("ack0", DW'(m0_ack), DW'(a0));
    check_eq("ack1", DW'(m1_ack), DW'(a1));
    check_eq("ack2", DW'(m2_ack), DW'(a2));

    check_eq("rvalid0", DW'(m0_rvalid), DW'(pend_rv[0]));
    check_eq("rvalid1", DW'(m1_rvalid), DW'(pend_rv[1]));
    check_eq("rvalid2", DW'(m2_rvalid), DW'(pend_rv[2]));
    if (pend_rv[0]) check_eq("rdata0", m0_rdata, pend_dat[0]);
    if (pend_rv[1]) check_eq("rdata1", m1_rdata, pend_dat[1]);
    if (pend_rv[2]) check_eq("rdata2", m2_rdata, pend_dat[2]);

    ewa = clr_on || (a0 && m0_we);
    ewb = clr_on || (a1 && m1_we) || (a2 && m2_we);
    check_eq("wea", DW'(ram_wea), DW'(ewa));
    check_eq("web", DW'(ram_web), DW'(ewb));
    check_eq("same_addr_writes", DW'(ram_wea && ram_web && (ram_addra == ram_addrb)), '0);
    if (clr_on) begin
      check_eq("clr_addra", DW'(ram_addra), DW'(2 * clr_k));
      check_eq("clr_addrb", DW'(ram_addrb), DW'(2 * clr_k + 1));
      check_eq("clr_dina", ram_dina, '0);
      check_eq("clr_dinb", ram_dinb, '0);
    end

    // Reads see memory contents from before this cycle's writes.
    nrv[0] = a0 && !m0_we; ndat[0] = ref_mem[m0_addr];
    nrv[1] = a1 && !m1_we; ndat[1] = ref_mem[m1_addr];
    nrv[2] = a2 && !m2_we; ndat[2] = ref_mem[m2_addr];

    ndone = 1'b0;
    if (clr_on) begin
      ref_mem[2 * clr_k]     = '0;
      ref_mem[2 * clr_k + 1] = '0;
      clr_k++;
      if (clr_k == DEPTH / 2) begin
        clr_on = 1'b0;
        ndone  = 1'b1;
      end
    end else if (clear_start) begin
      clr_on = 1'b1;
      clr_k  = 0;
    end
    if (a0 && m0_we) ref_mem[m0_addr] = m0_din;
    if (a1 && m1_we) ref_mem[m1_addr] = m1_din;
    if (a2 && m2_we) ref_mem[m2_addr] = m2_din;
    if (a1) fav = 2;
    else if (a2) fav = 1;

    for (int i = 0; i < 3; i++) begin
      pend_rv[i]  = nrv[i];
      pend_dat[i] = ndat[i];
    end
    done_flag = ndone;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic m0_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_din = din;
    step();
    m0_req = 1'b0; m0_we = 1'b0;
  endtask

  task automatic check_resets();
    check_eq("rst_busy", DW'(clear_busy), '0);
    check_eq("rst_done", DW'(clear_done), '0);
    check_eq("rst_rvalid0", DW'(m0_rvalid), '0);
    check_eq("rst_rvalid1", DW'(m1_rvalid), '0);
    check_eq("rst_rvalid2", DW'(m2_rvalid), '0);
    check_eq("rst_wea", DW'(ram_wea), '0);
    check_eq("rst_web", DW'(ram_web), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    busy_seen = 0;
    done_seen = 0;
    repeat (2) @(negedge clk);
    #1;
    check_resets();
    @(negedge clk);
    rst = 1'b1;

    // Write then read back on port A.
    m0_op(1'b1, 3'd5, 32'hA5);
    m0_op(1'b0, 3'd5, '0);
    step();

    // Port-B round-robin on reads of addresses 1 and 2.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 3'd1; m1_din = 32'h1111_0001;
    step();
    m1_req = 1'b0;
    m2_req = 1'b1; m2_we = 1'b1; m2_addr = 3'd2; m2_din = 32'h2222_0002;
    step();
    m1_req = 1'b1; m1_we = 1'b0;
    m2_we  = 1'b0;
    repeat (4) step();
    set_idle();
    step();

    // Full clear of a preloaded array.
    for (int i = 0; i < DEPTH; i++) m0_op(1'b1, AW'(i), 32'hC0DE_0000 + DW'(i) + 1);
    busy_seen = 0;
    done_seen = 0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (6) step();
    check_eq("busy_cycles", DW'(busy_seen), DW'(DEPTH / 2));
    check_eq("done_pulses", DW'(done_seen), DW'(1));
    for (int i = 0; i < DEPTH; i++) m0_op(1'b0, AW'(i), '0);
    step();

    // clear_start alongside m0/m1 requests held through the clear.
    m0_op(1'b1, 3'd3, 32'h3333);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 3'd4; m1_din = 32'h4444;
    step();
    m1_req = 1'b0;
    clear_start = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 3'd3;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 3'd4;
    step();
    clear_start = 1'b0;
    repeat (5) step();
    set_idle();
    step();

    // Random traffic with occasional clears.
    for (int c = 0; c < 400; c++) begin
      clear_start = ($urandom_range(0, 39) == 0);
      m0_req  = 1'($urandom_range(0, 1));
      m0_we   = 1'($urandom_range(0, 1));
      m0_addr = AW'($urandom_range(0, DEPTH - 1));
      m0_din  = $urandom;
      m1_req  = 1'($urandom_range(0, 1));
      m1_we   = 1'($urandom_range(0, 1));
      m1_addr = AW'($urandom_range(0, DEPTH - 1));
      m1_din  = $urandom;
      m2_req  = 1'($urandom_range(0, 1));
      m2_we   = 1'($urandom_range(0, 1));
      m2_addr = AW'($urandom_range(0, DEPTH - 1));
      m2_din  = $urandom;
      // Requesters never write the same address on both ports at once.
      if (m0_req && m0_we && m1_we && m1_addr == m0_addr) m1_addr = m1_addr ^ 3'd1;
      if (m0_req && m0_we && m2_we && m2_addr == m0_addr) m2_addr = m2_addr ^ 3'd1;
      step();
    end
    set_idle();
    for (int i = 0; i < 10 && clr_on; i++) step();
    step();
    for (int i = 0; i < DEPTH; i++) m0_op(1'b0, AW'(i), '0);
    step();

    // Reset two cycles into a clear.
    for (int i = 0; i < DEPTH; i++) m0_op(1'b1, AW'(i), 32'h7000_0000 + DW'(i) + 1);
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_resets();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    step();
    m0_op(1'b0, 3'd0, '0);
    m0_op(1'b0, 3'd7, '0);
    step();
    check_eq("no_done_after_rst", DW'(done_seen), '0);
    check_eq("addr7_kept", ref_mem[7], 32'h7000_0008);

    // Pointer favours m1 again after reset.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 3'd7;
    m2_req = 1'b1; m2_we = 1'b0; m2_addr = 3'd0;
    repeat (3) step();
    set_idle();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
